sm_display_driver: RTL and testbench

// - Downstream consumer of the sign-magnitude add/subtract stage.
// - Captures an N-bit sign-magnitude result and its carry (overflow) flag.
// - Converts the magnitude to BCD sequentially (double dabble, one bit per cycle).
// - Drives a 4-digit multiplexed 7-segment display: sign, hundreds, tens, units.

---
 rtl/sm_display_pkg.sv | 36 +++
 rtl/seg7_encoder.sv | 29 ++
 rtl/sm_display_driver.sv | 127 ++++++++++++
 tb/tb_sm_display_driver.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sm_display_pkg.sv
// Shared types, segment codes and the double-dabble step for the display driver.
package sm_display_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  typedef enum logic [3:0] {
    G_0, G_1, G_2, G_3, G_4, G_5, G_6, G_7, G_8, G_9,
    G_MINUS, G_BLANK, G_E
  } glyph_t;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  // One double-dabble iteration on the BCD part: add 3 to nibbles >= 5,
  // then shift left taking msb from the magnitude register.
  function automatic logic [11:0] dd_step(input logic [11:0] bcd, input logic msb);
    logic [11:0] a;
    for (int i = 0; i < 3; i++) begin
      a[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    return (a << 1) | {11'b0, msb};
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational glyph to active-low 7-segment pattern.
module seg7_encoder
  import sm_display_pkg::*;
(
  input  glyph_t     glyph,
  output logic [6:0] seg
);

  // Glyph lookup; unused codes fall back to blank
  always_comb begin
    seg = SEG_BLANK;
    case (glyph)
      G_0:     seg = SEG_0;
      G_1:     seg = SEG_1;
      G_2:     seg = SEG_2;
      G_3:     seg = SEG_3;
      G_4:     seg = SEG_4;
      G_5:     seg = SEG_5;
      G_6:     seg = SEG_6;
      G_7:     seg = SEG_7;
      G_8:     seg = SEG_8;
      G_9:     seg = SEG_9;
      G_MINUS: seg = SEG_MINUS;
      G_E:     seg = SEG_E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sm_display_driver.sv
// Sign-magnitude result capture, sequential binary-to-BCD conversion and
// 4-digit multiplexed 7-segment drive (sign, hundreds, tens, units).
//
// state | meaning
// IDLE  | waiting for in_load
// CONV  | one double-dabble shift per cycle, N-1 cycles
// DONE  | commit all four display registers together
module sm_display_driver
  import sm_display_pkg::*;
#(
  parameter int N       = 8,
  parameter int CLK_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_value,
  input  logic         in_carry,
  input  logic         in_load,
  output logic         o_busy,
  output logic [6:0]   o_seg,
  output logic [3:0]   o_an
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  state_t       state;
  logic [11:0]  bcd;
  logic [N-2:0] mag;
  logic [3:0]   iter;
  logic         sign_q;
  logic         carry_q;
  logic         mag_nz;
  glyph_t       disp_u, disp_t, disp_h, disp_s;

  logic [CW-1:0] ref_cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_next;
  glyph_t        glyph_sel;
  logic [6:0]    seg_next;

  // Conversion FSM with its datapath and the atomic display-register commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      o_busy  <= 1'b0;
      bcd     <= '0;
      mag     <= '0;
      iter    <= '0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      mag_nz  <= 1'b0;
      disp_u  <= G_0;
      disp_t  <= G_BLANK;
      disp_h  <= G_BLANK;
      disp_s  <= G_BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (in_load) begin
            mag     <= in_value[N-2:0];
            bcd     <= '0;
            sign_q  <= in_value[N-1];
            carry_q <= in_carry;
            mag_nz  <= |in_value[N-2:0];
            iter    <= 4'(N - 1);
            o_busy  <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd  <= dd_step(bcd, mag[N-2]);
          mag  <= mag << 1;
          iter <= iter - 4'd1;
          if (iter == 4'd1) state <= DONE;
        end
        DONE: begin
          disp_u <= glyph_t'(bcd[3:0]);
          disp_t <= (bcd[11:4] == 8'd0) ? G_BLANK : glyph_t'(bcd[7:4]);
          disp_h <= (bcd[11:8] == 4'd0) ? G_BLANK : glyph_t'(bcd[11:8]);
          disp_s <= carry_q ? G_E : ((sign_q && mag_nz) ? G_MINUS : G_BLANK);
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign idx_next = (ref_cnt == CNT_MAX) ? idx + 2'd1 : idx;

  // Digit selection for the single encoder on the multiplexed path
  always_comb begin
    glyph_sel = disp_u;
    case (idx_next)
      2'd0: glyph_sel = disp_u;
      2'd1: glyph_sel = disp_t;
      2'd2: glyph_sel = disp_h;
      2'd3: glyph_sel = disp_s;
      default: glyph_sel = disp_u;
    endcase
  end

  seg7_encoder u_enc (
    .glyph (glyph_sel),
    .seg   (seg_next)
  );

  // Free-running refresh scan with registered anode/segment outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      idx     <= 2'd0;
      o_an    <= 4'b1110;
      o_seg   <= SEG_0;
    end else begin
      ref_cnt <= (ref_cnt == CNT_MAX) ? '0 : ref_cnt + CW'(1);
      idx     <= idx_next;
      o_an    <= ~(4'b0001 << idx_next);
      o_seg   <= seg_next;
    end
  end

endmodule

// File: tb/tb_sm_display_driver.sv
// Directed bench for sm_display_driver with N = 8, CLK_DIV = 4.
module tb_sm_display_driver;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SM = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SE = 7'b0000110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_value = '0;
  logic       in_carry = 1'b0;
  logic       in_load = 1'b0;
  logic       o_busy;
  logic [6:0] o_seg;
  logic [3:0] o_an;

  int n_vec = 0;
  int n_err = 0;

  sm_display_driver #(.N(8), .CLK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_value (in_value),
    .in_carry (in_carry),
    .in_load  (in_load),
    .o_busy   (o_busy),
    .o_seg    (o_seg),
    .o_an     (o_an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] v, input logic c);
    @(negedge clk);
    in_value = v;
    in_carry = c;
    in_load  = 1'b1;
    @(negedge clk);
    in_load  = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (o_busy && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic scan(input string tag, input logic [6:0] u, input logic [6:0] t,
                      input logic [6:0] h, input logic [6:0] s);
    logic [3:0] pats [4];
    logic [6:0] exps [4];
    int k;
    pats = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exps = '{u, t, h, s};
    for (int d = 0; d < 4; d++) begin
      k = 0;
      while (o_an !== pats[d] && k < 20) begin
        @(negedge clk);
        k++;
      end
      check({tag, "_an"}, 32'(o_an), 32'(pats[d]));
      check({tag, "_seg"}, 32'(o_seg), 32'(exps[d]));
    end
  endtask

  initial begin
    int cyc;

    // reset held from time 0
    #12;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_an", 32'(o_an), 32'b1110);
    check("rst_seg", 32'(o_seg), 32'(S0));
    @(negedge clk);
    rst = 1'b0;

    // -5
    do_load(8'h85, 1'b0);
    check("m5_busy0", 32'(o_busy), 32'd1);
    wait_idle(cyc);
    check("m5_busy_len", 32'(cyc), 32'd8);
    @(negedge clk);
    scan("m5", S5, SB, SB, SM);

    // asynchronous reset mid-cycle while the sign digit is lit
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_an", 32'(o_an), 32'b1110);
    check("arst_seg", 32'(o_seg), 32'(S0));
    @(negedge clk);
    rst = 1'b0;

    // +127
    do_load(8'h7F, 1'b0);
    wait_idle(cyc);
    check("p127_busy_len", 32'(cyc), 32'd8);
    @(negedge clk);
    scan("p127", S7, S2, S1, SB);

    // negative zero
    do_load(8'h80, 1'b0);
    wait_idle(cyc);
    @(negedge clk);
    scan("nz", S0, SB, SB, SB);

    // carry set
    do_load(8'h03, 1'b1);
    wait_idle(cyc);
    @(negedge clk);
    scan("ovf", S3, SB, SB, SE);

    // load while busy is ignored
    do_load(8'h7F, 1'b0);
    @(negedge clk);
    in_value = 8'h01;
    in_load  = 1'b1;
    @(negedge clk);
    in_load  = 1'b0;
    check("ign_busy", 32'(o_busy), 32'd1);
    wait_idle(cyc);
    check("ign_busy_len", 32'(cyc), 32'd6);
    @(negedge clk);
    scan("ign", S7, S2, S1, SB);

    // reset during conversion
    do_load(8'h7F, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("crst_busy", 32'(o_busy), 32'd0);
    check("crst_an", 32'(o_an), 32'b1110);
    check("crst_seg", 32'(o_seg), 32'(S0));
    @(negedge clk);
    rst = 1'b0;
    do_load(8'h01, 1'b0);
    wait_idle(cyc);
    check("p1_busy_len", 32'(cyc), 32'd8);
    @(negedge clk);
    scan("p1", S1, SB, SB, SB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
